lsu_axi_bridge: RTL and testbench

//  Sits directly downstream of the memory stage. Takes its single-beat write and read

---
 rtl/lsu_axi_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_lsu_axi_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_bridge.sv
// Memory-stage to AXI4 master bridge: one single-beat read or write in flight at a time,
// with valid/ready request and valid/ready completion on the upstream side.
module lsu_axi_bridge #(
  parameter int              ADDR_W = 64,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream write request / completion
  input  logic              w_valid_i,
  output logic              w_ready_o,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [63:0]       w_data_i,
  input  logic [7:0]        w_mask_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  // upstream read request / completion
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [ADDR_W-1:0] r_addr_i,
  input  logic [7:0]        r_size_i,
  output logic [63:0]       data_read_o,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              bus_err,
  // AXI4 write address
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  // AXI4 write data
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI4 write response
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI4 read address
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  // AXI4 read data
  input  logic [ID_W-1:0]   rid,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // debug view of the FSM
  output logic [2:0]        dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge where
  // valid and ready are both 1; a valid side holds valid and payload stable until then.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    WR_DONE = 3'd3,
    RD_REQ  = 3'd4,
    RD_DATA = 3'd5,
    RD_DONE = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bus_err_q, bus_err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          wstrb_q, wstrb_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [63:0]         data_read_q, data_read_d;
  logic [2:0]          size_enc;
  logic                aw_done, w_done;
  logic                unused_inputs;

  // ID and last-beat flags are implied by the single-outstanding, single-beat protocol.
  assign unused_inputs = ^{bid, rid, rlast};

  always_comb begin
    case (r_size_i)
      8'd1:    size_enc = 3'd0;
      8'd2:    size_enc = 3'd1;
      8'd4:    size_enc = 3'd2;
      default: size_enc = 3'd3;
    endcase
  end

  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q || wready;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bus_err_d   = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arsize_d    = arsize_q;
    data_read_d = data_read_q;
    w_ready_o   = 1'b0;
    r_ready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        // Writes take priority; a simultaneous read keeps waiting with r_ready_o low.
        if (w_valid_i) begin
          w_ready_o = 1'b1;
          addr_d    = w_addr_i;
          wdata_d   = w_data_i;
          wstrb_d   = w_mask_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_REQ;
        end else if (r_valid_i) begin
          r_ready_o = 1'b1;
          addr_d    = r_addr_i;
          arsize_d  = size_enc;
          state_d   = RD_REQ;
        end
      end
      WR_REQ: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done)    state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          bus_err_d = (bresp != 2'b00);
          state_d   = WR_DONE;
        end
      end
      WR_DONE: begin
        if (w_ready_i) state_d = IDLE;
      end
      RD_REQ: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        // An error response still completes upstream; bus_err flags it alongside.
        if (rvalid) begin
          data_read_d = rdata;
          bus_err_d   = (rresp != 2'b00);
          state_d     = RD_DONE;
        end
      end
      RD_DONE: begin
        if (data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arsize_q    <= 3'd0;
      data_read_q <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bus_err_q   <= bus_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arsize_q    <= arsize_d;
      data_read_q <= data_read_d;
    end
  end

  // Channel strobes other than AW/W are pure decodes of the registered state.
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign bready      = (state_q == WR_RESP);
  assign arvalid     = (state_q == RD_REQ);
  assign rready      = (state_q == RD_DATA);
  assign w_valid_o   = (state_q == WR_DONE);
  assign data_valid  = (state_q == RD_DONE);
  assign bus_err     = bus_err_q;
  assign data_read_o = data_read_q;
  assign dbg_state_o = state_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'd3;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Bench for lsu_axi_bridge: delay-programmable AXI slave, directed scenarios, then random traffic.
module tb_lsu_axi_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        w_valid_i, w_ready_o, w_valid_o, w_ready_i;
  logic [63:0] w_addr_i, w_data_i;
  logic [7:0]  w_mask_i;
  logic        r_valid_i, r_ready_o;
  logic [63:0] r_addr_i;
  logic [7:0]  r_size_i;
  logic [63:0] data_read_o;
  logic        data_valid, data_ready, bus_err;
  logic [3:0]  awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, dbg_state;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  lsu_axi_bridge #(.ADDR_W(64), .ID_W(4), .AXI_ID(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .w_mask_i(w_mask_i), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_addr_i(r_addr_i), .r_size_i(r_size_i),
    .data_read_o(data_read_o), .data_valid(data_valid), .data_ready(data_ready), .bus_err(bus_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_state_o(dbg_state)
  );

  assign bid   = 4'h0;
  assign rid   = 4'h0;
  assign rlast = 1'b1;

  // ---------------- AXI slave model ----------------
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [63:0] cfg_rdata;
  logic        aw_seen, w_seen, ar_seen;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_done_now, w_done_now, ar_done_now;

  assign aw_done_now = aw_seen | (awvalid & awready);
  assign w_done_now  = w_seen  | (wvalid & wready);
  assign ar_done_now = ar_seen | (arvalid & arready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 0; wready <= 0; arready <= 0; bvalid <= 0; rvalid <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0;
      aw_seen <= 0; w_seen <= 0; ar_seen <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
    end else begin
      if (awvalid && awready) begin awready <= 0; aw_cnt <= 0; aw_seen <= 1; end
      else if (awvalid) begin if (aw_cnt >= aw_dly) awready <= 1; else aw_cnt <= aw_cnt + 1; end
      if (wvalid && wready) begin wready <= 0; w_cnt <= 0; w_seen <= 1; end
      else if (wvalid) begin if (w_cnt >= w_dly) wready <= 1; else w_cnt <= w_cnt + 1; end
      if (arvalid && arready) begin arready <= 0; ar_cnt <= 0; ar_seen <= 1; end
      else if (arvalid) begin if (ar_cnt >= ar_dly) arready <= 1; else ar_cnt <= ar_cnt + 1; end
      if (bvalid && bready) begin bvalid <= 0; aw_seen <= 0; w_seen <= 0; b_cnt <= 0; end
      else if (!bvalid && aw_done_now && w_done_now) begin
        if (b_cnt >= b_dly) begin bvalid <= 1; bresp <= cfg_bresp; end
        else b_cnt <= b_cnt + 1;
      end
      if (rvalid && rready) begin rvalid <= 0; ar_seen <= 0; r_cnt <= 0; end
      else if (!rvalid && ar_done_now) begin
        if (r_cnt >= r_dly) begin rvalid <= 1; rresp <= cfg_rresp; rdata <= cfg_rdata; end
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- beat log and protocol monitor ----------------
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, r_acc_cnt = 0;
  logic [63:0] log_awaddr, log_wdata, log_araddr;
  logic [7:0]  log_wstrb;
  logic        log_wlast;
  logic [16:0] log_awmeta, log_armeta;

  always @(posedge clk) begin
    if (rst_n) begin
      if (awvalid && awready) begin
        aw_hs <= aw_hs + 1; log_awaddr <= awaddr; log_awmeta <= {awid, awlen, awsize, awburst};
      end
      if (wvalid && wready) begin
        w_hs <= w_hs + 1; log_wdata <= wdata; log_wstrb <= wstrb; log_wlast <= wlast;
      end
      if (arvalid && arready) begin
        ar_hs <= ar_hs + 1; log_araddr <= araddr; log_armeta <= {arid, arlen, arsize, arburst};
      end
      if (r_ready_o) r_acc_cnt <= r_acc_cnt + 1;
    end
  end

  int          viol = 0, w_only_seen = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [63:0] p_awaddr, p_wdata, p_araddr;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_awv = 0; p_wv = 0; p_arv = 0; p_awr = 0; p_wr = 0; p_arr = 0;
    end else begin
      if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) viol++;
      if (p_wv && !p_wr && (!wvalid || wdata != p_wdata)) viol++;
      if (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) viol++;
      if (bready && (awvalid || wvalid)) viol++;
      if (!awvalid && wvalid) w_only_seen++;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  size_tab [6] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd3, 8'd0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AXI size field is log2 of the byte count for legal sizes, full 8 bytes otherwise.
  function automatic logic [2:0] ref_arsize(input logic [7:0] n);
    if (n == 8'd1 || n == 8'd2 || n == 8'd4 || n == 8'd8) return 3'($clog2(n));
    return 3'd3;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input bit is_wr);
    bit   seen;
    logic other;
    seen = 0; other = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (is_wr ? w_ready_o : r_ready_o) begin
        seen = 1; other = is_wr ? r_ready_o : w_ready_o; break;
      end
      @(negedge clk);
    end
    check(is_wr ? "w_accept" : "r_accept", 64'(seen), 64'd1);
    check("other_ready_low_on_accept", 64'(other), 64'd0);
    @(posedge clk); #1;
    if (is_wr) w_valid_i = 0; else r_valid_i = 0;
  endtask

  task automatic wait_done(input bit is_wr, input int exp_lat, input logic exp_err,
                           input logic [63:0] exp_data, input int hold);
    int    lat;
    string p;
    if (is_wr) p = "w"; else p = "r";
    lat = 0;
    while (lat < 400) begin
      @(negedge clk); lat++;
      if (is_wr ? w_valid_o : data_valid) break;
    end
    check({p, "_latency"}, 64'(lat), 64'(exp_lat));
    check({p, "_bus_err_pulse"}, 64'(bus_err), 64'(exp_err));
    if (!is_wr) check("read_data", data_read_o, exp_data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({p, "_completion_held"}, 64'(is_wr ? w_valid_o : data_valid), 64'd1);
      check({p, "_bus_err_one_cycle"}, 64'(bus_err), 64'd0);
      if (!is_wr) check("read_data_held", data_read_o, exp_data);
    end
    if (is_wr) w_ready_i = 1; else data_ready = 1;
    @(posedge clk); #1;
    w_ready_i = 0; data_ready = 0;
    @(negedge clk);
    check({p, "_completion_cleared"}, 64'(is_wr ? w_valid_o : data_valid), 64'd0);
    check({p, "_bus_err_cleared"}, 64'(bus_err), 64'd0);
  endtask

  task automatic check_wbeat(input int aw0, input int w0, input logic [63:0] a,
                             input logic [63:0] d, input logic [7:0] m);
    check("aw_beats", 64'(aw_hs - aw0), 64'd1);
    check("w_beats", 64'(w_hs - w0), 64'd1);
    check("awaddr", log_awaddr, a);
    check("wdata", log_wdata, d);
    check("wstrb", 64'(log_wstrb), 64'(m));
    check("wlast", 64'(log_wlast), 64'd1);
    check("aw_meta", 64'(log_awmeta), 64'({4'h0, 8'h00, 3'd3, 2'b01}));
  endtask

  task automatic write_txn(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                           input logic [1:0] resp, input int hold);
    int aw0, w0;
    aw0 = aw_hs; w0 = w_hs; cfg_bresp = resp;
    @(negedge clk);
    w_addr_i = a; w_data_i = d; w_mask_i = m; w_valid_i = 1;
    wait_accept(1);
    wait_done(1, 4 + max2(aw_dly, w_dly) + b_dly, resp != 2'b00, 64'd0, hold);
    check_wbeat(aw0, w0, a, d, m);
  endtask

  task automatic read_txn(input logic [63:0] a, input logic [7:0] size, input logic [63:0] rd,
                          input logic [1:0] resp, input int hold);
    int          ar0;
    logic [63:0] exp_d;
    ar0 = ar_hs; cfg_rresp = resp; cfg_rdata = rd; exp_q.push_back(rd);
    @(negedge clk);
    r_addr_i = a; r_size_i = size; r_valid_i = 1;
    wait_accept(0);
    exp_d = exp_q.pop_front();
    wait_done(0, 4 + ar_dly + r_dly, resp != 2'b00, exp_d, hold);
    check("ar_beats", 64'(ar_hs - ar0), 64'd1);
    check("araddr", log_araddr, a);
    check("ar_meta", 64'(log_armeta), 64'({4'h0, 8'h00, ref_arsize(size), 2'b01}));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          aw0, w0, ar0, ra0, wo;
    logic [63:0] exp_d;
    rst_n = 0;
    w_valid_i = 0; w_addr_i = 0; w_data_i = 0; w_mask_i = 0; w_ready_i = 0;
    r_valid_i = 0; r_addr_i = 0; r_size_i = 0; data_ready = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'({w_ready_o, r_ready_o, w_valid_o, data_valid, bus_err,
                                awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("reset_read_data", data_read_o, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // zero-wait write, completion 4 cycles after accept
    write_txn(64'h8000_0008, 64'h1122_3344_0000_0000, 8'hF0, 2'b00, 2);

    // AW accepted three cycles before W
    aw_dly = 0; w_dly = 3; wo = w_only_seen;
    write_txn(64'h8000_0100, 64'hCAFE_0000_1234_5678, 8'h0F, 2'b00, 1);
    check("w_held_after_aw_cycles", 64'(w_only_seen - wo), 64'd3);
    w_dly = 0;

    // read of 4 bytes with a slow data phase
    r_dly = 5;
    read_txn(64'h8000_0004, 8'd4, 64'hDEAD_BEEF_0000_0000, 2'b00, 3);
    r_dly = 0;

    // simultaneous write and read: write first, read after write completion is taken
    cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 64'h0BAD_F00D_1234_5678;
    exp_q.push_back(cfg_rdata);
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
    @(negedge clk);
    w_addr_i = 64'h8000_0200; w_data_i = 64'h0102_0304_0506_0708; w_mask_i = 8'hFF; w_valid_i = 1;
    r_addr_i = 64'h8000_0300; r_size_i = 8'd8; r_valid_i = 1;
    ra0 = r_acc_cnt;
    wait_accept(1);
    wait_done(1, 4, 1'b0, 64'd0, 1);
    check("read_held_during_write", 64'(r_acc_cnt - ra0), 64'd0);
    check_wbeat(aw0, w0, 64'h8000_0200, 64'h0102_0304_0506_0708, 8'hFF);
    wait_accept(0);
    exp_d = exp_q.pop_front();
    wait_done(0, 4, 1'b0, exp_d, 1);
    check("ar_beats_after_write", 64'(ar_hs - ar0), 64'd1);
    check("araddr_after_write", log_araddr, 64'h8000_0300);

    // SLVERR on B, then a normal read
    write_txn(64'h8000_0400, 64'h5555_AAAA_5555_AAAA, 8'h3C, 2'b10, 2);
    read_txn(64'h8000_0408, 8'd2, 64'h0000_0000_0000_BEEF, 2'b00, 0);

    // reset while AW is pending
    aw_dly = 30; w_dly = 30;
    aw0 = aw_hs; w0 = w_hs;
    @(negedge clk);
    w_addr_i = 64'h8000_0500; w_data_i = 64'hFFFF_0000_FFFF_0000; w_mask_i = 8'hAA; w_valid_i = 1;
    wait_accept(1);
    repeat (2) @(negedge clk);
    check("awvalid_before_reset", 64'(awvalid), 64'd1);
    rst_n = 0;
    #1;
    check("outputs_in_mid_reset", 64'({w_ready_o, r_ready_o, w_valid_o, data_valid, bus_err,
                                       awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    check("read_data_in_mid_reset", data_read_o, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1; aw_dly = 0; w_dly = 0;
    read_txn(64'h8000_0600, 8'd1, 64'h0000_0000_0000_0042, 2'b00, 1);
    check("no_stale_aw", 64'(aw_hs - aw0), 64'd0);
    check("no_stale_w", 64'(w_hs - w0), 64'd0);

    // random traffic
    for (int n = 0; n < 24; n++) begin
      logic [1:0] resp;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 1) == 1)
        write_txn({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), resp,
                  $urandom_range(0, 2));
      else
        read_txn({$urandom, $urandom}, size_tab[$urandom_range(0, 5)], {$urandom, $urandom},
                 resp, $urandom_range(0, 2));
    end

    check("protocol_violations", 64'(viol), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
